tx_byte_data_gen_mc: RTL and testbench

TX_BYTE_DATA_GEN_MC -- requirements
Module: tx_byte_data_gen_mc

---
 rtl/csi2_tx_pkg.sv | 20 ++
 rtl/tx_rr_arbiter.sv | 43 ++++
 rtl/tx_byte_data_gen_mc.sv | 161 ++++++++++++++++
 tb/tb_tx_byte_data_gen_mc.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_tx_pkg.sv
// Shared definitions for the CSI-2 transmit byte-data path: generator FSM
// encoding, channel limits and the legal packing-ratio rule.
package csi2_tx_pkg;

  localparam int MAX_CH    = 4;
  localparam int CH_W      = 2;
  localparam int MAX_RATIO = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_t;

  // Output/input width ratio must be a power of two in 1..MAX_RATIO.
  function automatic bit ratio_legal(input int r);
    return (r >= 1) && (r <= MAX_RATIO) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last-served
// channel; the pointer only moves when the caller enables an update.
module tx_rr_arbiter
  import csi2_tx_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] ptr;
  logic            found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found && req[k] && (k == (int'(ptr) + i) % NUM_CH)) begin
          found  = 1'b1;
          gnt[k] = 1'b1;
          idx    = CH_W'(k);
        end
      end
    end
  end

  // Pointer starts on the highest channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= CH_W'(NUM_CH - 1);
    end else if (en && found) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/tx_byte_data_gen_mc.sv
// Multi-channel byte-data generator: arbitrates per-packet between byte
// buffers and packs R consecutive IN_W-bit words into one OUT_W-bit word.
module tx_byte_data_gen_mc
  import csi2_tx_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int NO_LANE = 4,
  parameter int TX_GEAR = 8,
  parameter int OUT_W   = 64
) (
  input  logic                           tx_clk,
  input  logic                           rst_n_i,
  input  logic [NUM_CH*TX_GEAR*NO_LANE-1:0] byte_bufout_i,
  input  logic [NUM_CH-1:0]              lbfr_wdvalid_i,
  input  logic [NUM_CH-1:0]              lbf_lastwd_i,
  output logic [NUM_CH-1:0]              grant_o,
  input  logic                           gen_ready_i,
  output logic [OUT_W-1:0]               gen_word_o,
  output logic [OUT_W/8-1:0]             gen_be_o,
  output logic                           gen_data_valid_o,
  output logic                           gen_last_o,
  output logic [1:0]                     gen_ch_o,
  output logic [15:0]                    gen_wcnt_o
);

  localparam int IN_W   = TX_GEAR * NO_LANE;
  localparam int R      = OUT_W / IN_W;
  localparam int SLOT_W = (R > 1) ? $clog2(R) : 1;
  localparam int BPS    = IN_W / 8;
  localparam int BE_W   = OUT_W / 8;

  if (NUM_CH < 1 || NUM_CH > MAX_CH ||
      !(NO_LANE == 1 || NO_LANE == 2 || NO_LANE == 4) ||
      !(TX_GEAR == 8 || TX_GEAR == 16) ||
      (OUT_W % IN_W) != 0 || !ratio_legal(OUT_W / IN_W)) begin : g_param_check
    $error("tx_byte_data_gen_mc: illegal NUM_CH/NO_LANE/TX_GEAR/OUT_W combination");
  end

  gen_state_t          state, state_nxt;
  logic [NUM_CH-1:0]   arb_gnt;
  logic [CH_W-1:0]     arb_idx;
  logic [NUM_CH-1:0]   lock_gnt;
  logic [CH_W-1:0]     lock_ch;

  logic [IN_W-1:0]     in_word;
  logic                valid_sel, last_sel, slot_full, stall, block;
  logic                accept, complete;
  logic [OUT_W-1:0]    pack_fill;
  logic [BE_W-1:0]     be_fill;
  logic [15:0]         wcnt_nxt;

  logic [OUT_W-1:0]    pack_p0;
  logic [SLOT_W-1:0]   slot_p0;
  logic [15:0]         pkt_cnt;

  logic                vld_p1, last_p1;
  logic [OUT_W-1:0]    word_p1;
  logic [BE_W-1:0]     be_p1;
  logic [CH_W-1:0]     ch_p1;
  logic [15:0]         wcnt_p1;

  tx_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk   (tx_clk),
    .rst_n (rst_n_i),
    .req   (lbfr_wdvalid_i),
    .en    (state == ST_IDLE),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  always_ff @(posedge tx_clk) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|lbfr_wdvalid_i)     state_nxt = ST_LOCK;
      ST_LOCK: if (accept && last_sel)  state_nxt = ST_GAP;
      ST_GAP:                           state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Stage 0: select locked channel, decide acceptance and build the fill.
  always_comb begin
    in_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (lock_gnt[k]) in_word = byte_bufout_i[k*IN_W +: IN_W];
    end
    valid_sel = |(lock_gnt & lbfr_wdvalid_i);
    last_sel  = |(lock_gnt & lbfr_wdvalid_i & lbf_lastwd_i);
    slot_full = (slot_p0 == SLOT_W'(R - 1));
    stall     = vld_p1 && !gen_ready_i;
    // A completing word cannot be taken while the output register is held.
    block     = stall && (slot_full || (last_sel && valid_sel));
    grant_o   = (state == ST_LOCK && !block) ? lock_gnt : '0;
    accept    = |(grant_o & lbfr_wdvalid_i);
    complete  = accept && (slot_full || last_sel);
    pack_fill = pack_p0 | (OUT_W'(in_word) << (int'(slot_p0) * IN_W));
    be_fill   = '0;
    for (int s = 0; s < R; s++) begin
      if (s <= int'(slot_p0)) be_fill[s*BPS +: BPS] = '1;
    end
    wcnt_nxt  = (pkt_cnt == 16'hFFFF) ? pkt_cnt : pkt_cnt + 16'd1;
  end

  always_ff @(posedge tx_clk) begin
    if (!rst_n_i) begin
      lock_gnt <= '0;
      lock_ch  <= '0;
      pack_p0  <= '0;
      slot_p0  <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (state == ST_IDLE && |lbfr_wdvalid_i) begin
        lock_gnt <= arb_gnt;
        lock_ch  <= arb_idx;
        pkt_cnt  <= '0;
      end
      if (complete) begin
        pack_p0 <= '0;
        slot_p0 <= '0;
        pkt_cnt <= wcnt_nxt;
      end else if (accept) begin
        pack_p0 <= pack_fill;
        slot_p0 <= slot_p0 + 1'b1;
      end
    end
  end

  // Stage 1: output register, held while downstream stalls.
  always_ff @(posedge tx_clk) begin
    if (!rst_n_i) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      be_p1   <= '0;
      last_p1 <= 1'b0;
      ch_p1   <= '0;
      wcnt_p1 <= '0;
    end else if (complete) begin
      vld_p1  <= 1'b1;
      word_p1 <= pack_fill;
      be_p1   <= be_fill;
      last_p1 <= last_sel;
      ch_p1   <= lock_ch;
      wcnt_p1 <= wcnt_nxt;
    end else if (gen_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign gen_word_o       = word_p1;
  assign gen_be_o         = be_p1;
  assign gen_data_valid_o = vld_p1;
  assign gen_last_o       = last_p1;
  assign gen_ch_o         = ch_p1;
  assign gen_wcnt_o       = wcnt_p1;

endmodule

// File: tb/tb_tx_byte_data_gen_mc.sv
// Bench for tx_byte_data_gen_mc: packet-level reference model, directed
// literal scenarios, randomized multi-channel traffic and an R=1 instance.
module tb_tx_byte_data_gen_mc;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 64;
  localparam int R      = OUT_W / IN_W;
  localparam int BE_W   = OUT_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n = 1'b0;
  logic [NUM_CH*IN_W-1:0]   data  = '0;
  logic [NUM_CH-1:0]        valid = '0;
  logic [NUM_CH-1:0]        last  = '0;
  logic                     ready = 1'b1;
  logic [NUM_CH-1:0]        grant;
  logic [OUT_W-1:0]         gword;
  logic [BE_W-1:0]          gbe;
  logic                     gvalid, glast;
  logic [1:0]               gch;
  logic [15:0]              gwcnt;

  logic [127:0]             r1_data  = '0;
  logic [1:0]               r1_valid = '0;
  logic [1:0]               r1_last  = '0;
  logic [1:0]               r1_grant;
  logic [63:0]              r1_word;
  logic [7:0]               r1_be;
  logic                     r1_dv, r1_gl;
  logic [1:0]               r1_ch;
  logic [15:0]              r1_wcnt;

  tx_byte_data_gen_mc #(.NUM_CH(NUM_CH), .NO_LANE(4), .TX_GEAR(8), .OUT_W(OUT_W)) u_dut (
    .tx_clk           (clk),
    .rst_n_i          (rst_n),
    .byte_bufout_i    (data),
    .lbfr_wdvalid_i   (valid),
    .lbf_lastwd_i     (last),
    .grant_o          (grant),
    .gen_ready_i      (ready),
    .gen_word_o       (gword),
    .gen_be_o         (gbe),
    .gen_data_valid_o (gvalid),
    .gen_last_o       (glast),
    .gen_ch_o         (gch),
    .gen_wcnt_o       (gwcnt)
  );

  tx_byte_data_gen_mc #(.NUM_CH(2), .NO_LANE(4), .TX_GEAR(16), .OUT_W(64)) u_r1 (
    .tx_clk           (clk),
    .rst_n_i          (rst_n),
    .byte_bufout_i    (r1_data),
    .lbfr_wdvalid_i   (r1_valid),
    .lbf_lastwd_i     (r1_last),
    .grant_o          (r1_grant),
    .gen_ready_i      (1'b1),
    .gen_word_o       (r1_word),
    .gen_be_o         (r1_be),
    .gen_data_valid_o (r1_dv),
    .gen_last_o       (r1_gl),
    .gen_ch_o         (r1_ch),
    .gen_wcnt_o       (r1_wcnt)
  );

  typedef struct packed { logic [31:0] d; logic l; } wd_t;
  typedef struct packed {
    logic [63:0] w; logic [7:0] be; logic l; logic [1:0] ch; logic [15:0] wc; logic [31:0] cyc;
  } cap_t;

  wd_t  q[NUM_CH][$];
  cap_t cap[$];
  cap_t r1cap[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit noise_en = 1'b0;
  logic [NUM_CH-1:0] acc_mask = '0;
  logic [1:0]        r1_acc   = '0;

  // Reference model state: packet phase, owner, round-robin pointer,
  // collected words of the output word in progress, and expected outputs.
  int          m_phase, m_owner, m_ptr, m_slot, m_cnt;
  logic [31:0] m_words[R];
  logic        e_valid, e_last;
  logic [63:0] e_word;
  logic [7:0]  e_be;
  logic [1:0]  e_ch;
  logic [15:0] e_wcnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_ptr = NUM_CH - 1; m_slot = 0; m_cnt = 0;
    for (int s = 0; s < R; s++) m_words[s] = '0;
    e_valid = 1'b0; e_last = 1'b0; e_word = '0; e_be = '0; e_ch = '0; e_wcnt = '0;
  endfunction

  initial begin
    model_reset();
    forever begin
      logic [NUM_CH-1:0] eg;
      logic stall, wouldc, lastw, acc;
      int pick;
      cap_t c;
      @(negedge clk);
      eg = '0;
      stall = e_valid && !ready;
      lastw = valid[m_owner] && last[m_owner];
      if (m_phase == 1) begin
        wouldc = (m_slot == R - 1) || lastw;
        if (!(stall && wouldc)) eg[m_owner] = 1'b1;
      end
      check("grant_o", grant, eg);
      check("gen_data_valid_o", gvalid, e_valid);
      if (e_valid) begin
        check("gen_word_o", gword, e_word);
        check("gen_be_o", gbe, e_be);
        check("gen_last_o", glast, e_last);
        check("gen_ch_o", gch, e_ch);
        check("gen_wcnt_o", gwcnt, e_wcnt);
      end
      if (rst_n && gvalid && ready) begin
        c.w = gword; c.be = gbe; c.l = glast; c.ch = gch; c.wc = gwcnt; c.cyc = cyc;
        cap.push_back(c);
      end
      if (rst_n && r1_dv) begin
        c.w = r1_word; c.be = r1_be; c.l = r1_gl; c.ch = r1_ch; c.wc = r1_wcnt; c.cyc = cyc;
        r1cap.push_back(c);
      end
      acc_mask = rst_n ? (grant & valid) : '0;
      r1_acc   = rst_n ? (r1_grant & r1_valid) : '0;

      if (!rst_n) begin
        model_reset();
      end else begin
        acc = (eg != '0) && valid[m_owner];
        if (e_valid && ready) e_valid = 1'b0;
        if (acc) begin
          m_words[m_slot] = data[m_owner*IN_W +: IN_W];
          if (m_slot == R - 1 || lastw) begin
            e_word = '0;
            for (int s = 0; s <= m_slot; s++) e_word[s*IN_W +: IN_W] = m_words[s];
            e_be   = 8'((1 << ((m_slot + 1) * (IN_W / 8))) - 1);
            e_last = lastw;
            e_ch   = 2'(m_owner);
            if (m_cnt < 65535) m_cnt++;
            e_wcnt = 16'(m_cnt);
            e_valid = 1'b1;
            m_slot = 0;
          end else begin
            m_slot++;
          end
        end
        case (m_phase)
          0: if (|valid) begin
               pick = 0;
               for (int i = 1; i <= NUM_CH; i++) begin
                 pick = (m_ptr + i) % NUM_CH;
                 if (valid[pick]) break;
               end
               m_owner = pick; m_ptr = pick; m_cnt = 0; m_phase = 1;
             end
          1: if (acc && lastw) m_phase = 2;
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic drive_inputs();
    for (int k = 0; k < NUM_CH; k++) begin
      if (q[k].size() > 0) begin
        valid[k] = 1'b1;
        last[k]  = q[k][0].l;
        data[k*IN_W +: IN_W] = q[k][0].d;
      end else begin
        valid[k] = 1'b0;
        last[k]  = noise_en ? 1'($urandom % 2) : 1'b0;
        data[k*IN_W +: IN_W] = $urandom;
      end
    end
  endtask

  task automatic step(input bit rdy, input bit rst_val);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) q[k].delete();
    end else begin
      for (int k = 0; k < NUM_CH; k++) if (acc_mask[k]) void'(q[k].pop_front());
    end
    rst_n = rst_val;
    ready = rdy;
    drive_inputs();
  endtask

  task automatic push_pkt(input int k, input int len, input logic [31:0] base, input bit rnd);
    wd_t w;
    for (int i = 0; i < len; i++) begin
      w.d = rnd ? $urandom : base + 32'(i);
      w.l = (i == len - 1);
      q[k].push_back(w);
    end
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    int b = 0;
    while (cap.size() < n && b < budget) begin
      step(1'b1, 1'b1);
      b++;
    end
    if (cap.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got %0d output words, expected %0d", tag, cap.size(), n);
    end
  endtask

  task automatic check_out(input string tag, input int i, input logic [63:0] w,
                           input logic [7:0] be, input logic l, input logic [1:0] ch,
                           input logic [15:0] wc);
    if (i < cap.size()) begin
      check({tag, " word"}, cap[i].w, w);
      check({tag, " be"}, cap[i].be, be);
      check({tag, " last"}, cap[i].l, l);
      check({tag, " ch"}, cap[i].ch, ch);
      check({tag, " wcnt"}, cap[i].wc, wc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r1w[2];
    int idx;
    int csz;

    // Reset values
    repeat (3) step(1'b1, 1'b0);
    @(negedge clk);
    check("reset grant_o", grant, 0);
    check("reset gen_word_o", gword, 0);
    check("reset gen_be_o", gbe, 0);
    check("reset gen_data_valid_o", gvalid, 0);
    check("reset gen_last_o", glast, 0);
    check("reset gen_ch_o", gch, 0);
    check("reset gen_wcnt_o", gwcnt, 0);
    step(1'b1, 1'b1);

    // Four-word packet on channel 0
    cap.delete();
    push_pkt(0, 4, 32'hA000_0000, 1'b0);
    wait_caps(2, 40, "ch0_4w");
    check_out("ch0_4w[0]", 0, 64'hA000_0001_A000_0000, 8'hFF, 1'b0, 2'd0, 16'd1);
    check_out("ch0_4w[1]", 1, 64'hA000_0003_A000_0002, 8'hFF, 1'b1, 2'd0, 16'd2);

    // Odd-length packet on channel 1
    cap.delete();
    push_pkt(1, 3, 32'hB000_0000, 1'b0);
    wait_caps(2, 40, "ch1_3w");
    check_out("ch1_3w[0]", 0, 64'hB000_0001_B000_0000, 8'hFF, 1'b0, 2'd1, 16'd1);
    check_out("ch1_3w[1]", 1, 64'h0000_0000_B000_0002, 8'h0F, 1'b1, 2'd1, 16'd2);

    // Downstream stall of 5 cycles mid-packet
    cap.delete();
    push_pkt(2, 6, 32'hC000_0000, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    wait_caps(3, 60, "stall");
    check("stall output count", cap.size(), 3);
    check_out("stall[0]", 0, 64'hC000_0001_C000_0000, 8'hFF, 1'b0, 2'd2, 16'd1);
    check_out("stall[1]", 1, 64'hC000_0003_C000_0002, 8'hFF, 1'b0, 2'd2, 16'd2);
    check_out("stall[2]", 2, 64'hC000_0005_C000_0004, 8'hFF, 1'b1, 2'd2, 16'd3);

    // All channels requesting after reset: order 0,1,2,3,0
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    cap.delete();
    push_pkt(0, 2, 32'h1000_0000, 1'b0);
    push_pkt(0, 2, 32'h1000_0010, 1'b0);
    push_pkt(1, 2, 32'h1100_0000, 1'b0);
    push_pkt(2, 2, 32'h1200_0000, 1'b0);
    push_pkt(3, 2, 32'h1300_0000, 1'b0);
    wait_caps(5, 80, "rr");
    check_out("rr[0]", 0, 64'h1000_0001_1000_0000, 8'hFF, 1'b1, 2'd0, 16'd1);
    check_out("rr[1]", 1, 64'h1100_0001_1100_0000, 8'hFF, 1'b1, 2'd1, 16'd1);
    check_out("rr[2]", 2, 64'h1200_0001_1200_0000, 8'hFF, 1'b1, 2'd2, 16'd1);
    check_out("rr[3]", 3, 64'h1300_0001_1300_0000, 8'hFF, 1'b1, 2'd3, 16'd1);
    check_out("rr[4]", 4, 64'h1000_0011_1000_0010, 8'hFF, 1'b1, 2'd0, 16'd1);

    // Reset pulse mid-packet discards the partial word
    cap.delete();
    push_pkt(1, 3, 32'hD000_0000, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    @(negedge clk);
    check("midrst grant_o", grant, 0);
    check("midrst gen_data_valid_o", gvalid, 0);
    check("midrst gen_word_o", gword, 0);
    check("midrst gen_be_o", gbe, 0);
    check("midrst gen_wcnt_o", gwcnt, 0);
    repeat (6) step(1'b1, 1'b1);
    check("midrst no partial output", cap.size(), 0);
    push_pkt(3, 1, 32'hE300_0000, 1'b0);
    push_pkt(0, 1, 32'hE000_0000, 1'b0);
    wait_caps(2, 40, "midrst_next");
    check_out("midrst_next[0]", 0, 64'h0000_0000_E000_0000, 8'h0F, 1'b1, 2'd0, 16'd1);
    check_out("midrst_next[1]", 1, 64'h0000_0000_E300_0000, 8'h0F, 1'b1, 2'd3, 16'd1);

    // R = 1 instance: two-word packet, outputs on consecutive cycles
    r1w[0] = 64'h0123_4567_89AB_CDEF;
    r1w[1] = 64'hFEDC_BA98_7654_3210;
    r1cap.delete();
    idx = 0;
    r1_valid = 2'b01; r1_data[63:0] = r1w[0]; r1_last = 2'b00;
    for (int b = 0; b < 30 && r1cap.size() < 2; b++) begin
      step(1'b1, 1'b1);
      if (r1_acc[0]) idx++;
      if (idx < 2) begin
        r1_valid = 2'b01; r1_data[63:0] = r1w[idx]; r1_last = (idx == 1) ? 2'b01 : 2'b00;
      end else begin
        r1_valid = 2'b00; r1_last = 2'b00;
      end
    end
    r1_valid = 2'b00; r1_last = 2'b00;
    check("r1 output count", r1cap.size(), 2);
    if (r1cap.size() >= 2) begin
      check("r1[0] word", r1cap[0].w, r1w[0]);
      check("r1[0] be", r1cap[0].be, 8'hFF);
      check("r1[0] last", r1cap[0].l, 1'b0);
      check("r1[0] wcnt", r1cap[0].wc, 16'd1);
      check("r1[1] word", r1cap[1].w, r1w[1]);
      check("r1[1] be", r1cap[1].be, 8'hFF);
      check("r1[1] last", r1cap[1].l, 1'b1);
      check("r1[1] wcnt", r1cap[1].wc, 16'd2);
      check("r1 consecutive", 64'(r1cap[1].cyc - r1cap[0].cyc), 64'd1);
    end

    // Randomized traffic: saturated start, then sparse packets with
    // random stalls, lastwd noise on idle channels and rare resets.
    noise_en = 1'b1;
    cap.delete();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (q[k].size() == 0 && (t < 600 || ($urandom % 6) == 0))
          push_pkt(k, $urandom_range(1, 7), 32'h0, 1'b1);
      end
      step(($urandom % 4) != 0, ($urandom % 700) != 0);
    end
    noise_en = 1'b0;
    csz = 0;
    for (int t = 0; t < 200; t++) begin
      step(1'b1, 1'b1);
      csz = 0;
      for (int k = 0; k < NUM_CH; k++) csz += q[k].size();
      if (csz == 0 && !gvalid) break;
    end
    check("drain pending words", csz, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
